// File: rtl/embed_onchip_ram_dp_if.sv
// Avalon-MM slave port bundle for the dual-port on-chip RAM.
// One instance per slave port; the RAM takes two of them.
interface embed_onchip_ram_dp_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 12
);
    logic [ADDR_WIDTH-1:0]   address;
    logic                    chipselect;
    logic                    read;
    logic                    write;
    logic [DATA_WIDTH/8-1:0] byteenable;
    logic [DATA_WIDTH-1:0]   writedata;
    logic [DATA_WIDTH-1:0]   readdata;
    logic                    readdatavalid;
    logic                    waitrequest;

    modport master (
        output address, chipselect, read, write, byteenable, writedata,
        input  readdata, readdatavalid, waitrequest
    );

    modport slave (
        input  address, chipselect, read, write, byteenable, writedata,
        output readdata, readdatavalid, waitrequest
    );
endinterface

// File: rtl/embed_onchip_ram_dp.sv
// Dual-port Avalon-MM on-chip RAM with per-byte write enables, an optional
// zero-fill sequence after reset, 1- or 2-cycle read latency and a sticky
// out-of-range access flag. Port 1 wins a same-address write collision.
module embed_onchip_ram_dp #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 12,
    parameter int DEPTH          = 4000,
    parameter int READ_LATENCY   = 1,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    embed_onchip_ram_dp_if.slave s1,
    embed_onchip_ram_dp_if.slave s2,
    output logic                 init_done,
    output logic                 oor_err
);

    localparam int BYTES = DATA_WIDTH / 8;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    typedef enum logic {
        ST_CLEAR,
        ST_READY
    } state_t;

    localparam state_t RESET_STATE = CLEAR_ON_RESET ? ST_CLEAR : ST_READY;

    state_t            state;
    state_t            state_next;
    logic [IDX_W-1:0]  clr_idx;
    logic              clr_we;
    logic              stall;

    // Both slave ports gathered into arrays so the per-port logic is written once.
    logic [ADDR_WIDTH-1:0] p_addr [2];
    logic                  p_cs   [2];
    logic                  p_rd   [2];
    logic                  p_wr   [2];
    logic [BYTES-1:0]      p_be   [2];
    logic [DATA_WIDTH-1:0] p_wd   [2];

    assign p_addr[0] = s1.address;    assign p_addr[1] = s2.address;
    assign p_cs[0]   = s1.chipselect; assign p_cs[1]   = s2.chipselect;
    assign p_rd[0]   = s1.read;       assign p_rd[1]   = s2.read;
    assign p_wr[0]   = s1.write;      assign p_wr[1]   = s2.write;
    assign p_be[0]   = s1.byteenable; assign p_be[1]   = s2.byteenable;
    assign p_wd[0]   = s1.writedata;  assign p_wd[1]   = s2.writedata;

    logic             acc      [2];
    logic             in_range [2];
    logic             rd_en    [2];
    logic             wr_en    [2];
    logic [IDX_W-1:0] idx      [2];

    for (genvar i = 0; i < 2; i++) begin : g_port
        assign acc[i]      = p_cs[i] & (p_rd[i] | p_wr[i]) & ~stall;
        assign in_range[i] = (32'(p_addr[i]) < 32'(DEPTH));
        // Read and write together count as a write only.
        assign rd_en[i]    = acc[i] & p_rd[i] & ~p_wr[i];
        assign idx[i]      = p_addr[i][IDX_W-1:0];
    end

    // Port 2's write is dropped entirely when port 1 writes the same word.
    assign wr_en[0] = acc[0] & p_wr[0] & in_range[0];
    assign wr_en[1] = acc[1] & p_wr[1] & in_range[1] & ~(wr_en[0] && (idx[0] == idx[1]));

    // Controller state register.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= RESET_STATE;
        else          state <= state_next;
    end

    // Next-state: leave CLEAR after the last word has been zeroed.
    always_comb begin
        state_next = state;
        case (state)
            ST_CLEAR: if (clr_idx == LAST_IDX) state_next = ST_READY;
            ST_READY: state_next = ST_READY;
            default:  state_next = RESET_STATE;
        endcase
    end

    // Controller outputs: stall both ports and drive the clear write while clearing.
    // NOTE: every always_comb output gets a default first, so no path infers a latch.
    always_comb begin
        stall     = 1'b0;
        clr_we    = 1'b0;
        init_done = 1'b0;
        case (state)
            ST_CLEAR: begin
                stall  = 1'b1;
                clr_we = 1'b1;
            end
            ST_READY: init_done = 1'b1;
            default:  stall = 1'b1;
        endcase
    end

    // Clear address counter; restarts from zero on every reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)    clr_idx <= '0;
        else if (clr_we) clr_idx <= (clr_idx == LAST_IDX) ? '0 : clr_idx + 1'b1;
    end

    // Storage array: zero-fill during CLEAR, byte-masked writes from both ports.
    // NOTE: the array itself is never reset; zeroing it is the job of the CLEAR sequence.
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (clr_we) mem[clr_idx] <= '0;
        for (int i = 0; i < 2; i++) begin
            if (wr_en[i]) begin
                for (int b = 0; b < BYTES; b++) begin
                    if (p_be[i][b]) mem[idx[i]][b*8 +: 8] <= p_wd[i][b*8 +: 8];
                end
            end
        end
    end

    // Array read port; sees pre-write contents, giving read-old-data on collisions.
    logic [DATA_WIDTH-1:0] rd_word [2];

    always_ff @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rd_en[i] && in_range[i]) rd_word[i] <= mem[idx[i]];
        end
    end

    // First read stage control: valid and out-of-range marker per port.
    logic rd_vld1 [2];
    logic rd_oor1 [2];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 2; i++) begin
                rd_vld1[i] <= 1'b0;
                rd_oor1[i] <= 1'b0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                rd_vld1[i] <= rd_en[i];
                rd_oor1[i] <= rd_en[i] & ~in_range[i];
            end
        end
    end

    // First stage data, forced to zero when idle or out of range.
    logic [DATA_WIDTH-1:0] stg1_data [2];

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            stg1_data[i] = '0;
            if (rd_vld1[i] && !rd_oor1[i]) stg1_data[i] = rd_word[i];
        end
    end

    logic                  out_vld  [2];
    logic [DATA_WIDTH-1:0] out_data [2];

    if (READ_LATENCY == 2) begin : g_lat2
        // Extra output register stage; data is already zero whenever valid is low.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                for (int i = 0; i < 2; i++) begin
                    out_vld[i]  <= 1'b0;
                    out_data[i] <= '0;
                end
            end else begin
                for (int i = 0; i < 2; i++) begin
                    out_vld[i]  <= rd_vld1[i];
                    out_data[i] <= stg1_data[i];
                end
            end
        end
    end else begin : g_lat1
        always_comb begin
            for (int i = 0; i < 2; i++) begin
                out_vld[i]  = rd_vld1[i];
                out_data[i] = stg1_data[i];
            end
        end
    end

    // Sticky out-of-range flag, set the cycle after any accepted bad access.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) oor_err <= 1'b0;
        else if ((acc[0] && !in_range[0]) || (acc[1] && !in_range[1])) oor_err <= 1'b1;
    end

    assign s1.readdata      = out_data[0];
    assign s1.readdatavalid = out_vld[0];
    assign s1.waitrequest   = stall;
    assign s2.readdata      = out_data[1];
    assign s2.readdatavalid = out_vld[1];
    assign s2.waitrequest   = stall;

endmodule
